mam_host_packetizer: RTL and testbench

MAM_HOST_PACKETIZER -- requirements
Module: mam_host_packetizer

---
 rtl/dii_package.sv | 10 +
 rtl/mam_host_packetizer_pkg.sv | 32 +++
 rtl/mam_host_packetizer_if.sv | 36 +++
 rtl/mam_host_packetizer.sv | 194 +++++++++++++++++++
 tb/tb_mam_host_packetizer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dii_package.sv
// Debug interconnect flit type shared by every module that talks to the ring.
package dii_package;

   typedef struct packed {
      logic [15:0] data;
      logic        last;
      logic        valid;
   } dii_flit;

endpackage

// File: rtl/mam_host_packetizer_pkg.sv
// MAM packet format constants and packetizer FSM state type.
package mam_host_packetizer_pkg;

   // MAM header flit layout
   localparam int unsigned MAM_HDR_RW        = 15;
   localparam int unsigned MAM_HDR_BURST     = 14;
   localparam int unsigned MAM_HDR_BEATS_MSB = 13;

   // Type prefixes placed above the 10-bit module IDs
   localparam logic [5:0] MAM_DEST_TYPE = 6'h00;
   localparam logic [5:0] MAM_SRC_TYPE  = 6'h10;

   typedef enum logic [2:0] {
      StIdle,
      StDest,
      StSrc,
      StHdr,
      StAddr,
      StData
   } pkt_state_e;

   function automatic logic [15:0] mam_hdr(input logic rw, input logic burst,
                                           input logic [13:0] beats);
      logic [15:0] hdr;
      hdr                          = '0;
      hdr[MAM_HDR_RW]              = rw;
      hdr[MAM_HDR_BURST]           = burst;
      hdr[MAM_HDR_BEATS_MSB:0]     = beats;
      return hdr;
   endfunction

endpackage

// File: rtl/mam_host_packetizer_if.sv
// Host command / write-data / ring-output bundle of the MAM host packetizer.
interface mam_host_packetizer_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 32
);
   import dii_package::*;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_rw;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic                  cmd_burst;
   logic [13:0]           cmd_beats;

   logic                  wdata_valid;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  wdata_ready;

   dii_flit               debug_out;
   logic                  debug_out_ready;

   // Host and ring side
   modport master (
      output cmd_valid, cmd_rw, cmd_addr, cmd_burst, cmd_beats,
      output wdata_valid, wdata, debug_out_ready,
      input  cmd_ready, wdata_ready, debug_out
   );

   // Packetizer side
   modport slave (
      input  cmd_valid, cmd_rw, cmd_addr, cmd_burst, cmd_beats,
      input  wdata_valid, wdata, debug_out_ready,
      output cmd_ready, wdata_ready, debug_out
   );

endinterface

// File: rtl/mam_host_packetizer.sv
// Turns MAM read/write commands into DEST/SRC/HDR/ADDR/DATA flits on the debug ring,
// splitting long write bursts into continuation packets of at most MAX_PKT_LEN flits.
module mam_host_packetizer
   import dii_package::*;
   import mam_host_packetizer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned MAX_PKT_LEN = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [9:0]           id,
   input  logic [9:0]           mam_id,
   mam_host_packetizer_if.slave bus
);

   localparam int unsigned WordFlits = DATA_WIDTH / 16;
   localparam int unsigned AddrFlits = ADDR_WIDTH / 16;
   localparam int unsigned CntW      = $clog2(MAX_PKT_LEN + 1);
   localparam int unsigned SubW      = (WordFlits > 1) ? $clog2(WordFlits) : 1;
   localparam int unsigned AidxW     = (AddrFlits > 1) ? $clog2(AddrFlits) : 1;
   localparam logic [SubW-1:0]  SubLast  = SubW'(WordFlits - 1);
   localparam logic [AidxW-1:0] AidxLast = AidxW'(AddrFlits - 1);

   pkt_state_e            state_q, state_d;
   dii_flit               flit_q, flit_d;
   logic                  rw_q, rw_d;
   logic [15:0]           hdr_q, hdr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [13:0]           rem_q, rem_d;
   logic [CntW-1:0]       pkt_cnt_q, pkt_cnt_d;
   logic [AidxW-1:0]      aidx_q, aidx_d;
   logic [SubW-1:0]       sidx_q, sidx_d;
   logic                  cont_q, cont_d;

   logic        load;
   logic        burst_eff;
   logic        pkt_full;
   logic [15:0] addr_chunk;
   logic [15:0] data_chunk;

   // Output register may take a new flit when empty or being drained this cycle
   assign load      = !flit_q.valid || bus.debug_out_ready;
   // A burst of zero beats degenerates to a single access
   assign burst_eff = bus.cmd_burst && (bus.cmd_beats != '0);
   // After this flit, another whole word would no longer fit into the packet
   assign pkt_full  = (32'(pkt_cnt_q) + 32'd1 + 32'(WordFlits)) > 32'(MAX_PKT_LEN);

   assign bus.cmd_ready = (state_q == StIdle);
   assign bus.debug_out = flit_q;

   // Select the 16-bit address and data slices, most significant first
   always_comb begin
      addr_chunk = '0;
      data_chunk = '0;
      for (int i = 0; i < int'(AddrFlits); i++) begin
         if (aidx_q == AidxW'(i)) addr_chunk = addr_q[ADDR_WIDTH-1-16*i -: 16];
      end
      for (int i = 0; i < int'(WordFlits); i++) begin
         if (sidx_q == SubW'(i)) data_chunk = bus.wdata[DATA_WIDTH-1-16*i -: 16];
      end
   end

   // Next-state, flit generation and write-data consumption
   always_comb begin
      state_d         = state_q;
      flit_d          = flit_q;
      rw_d            = rw_q;
      hdr_d           = hdr_q;
      addr_d          = addr_q;
      rem_d           = rem_q;
      pkt_cnt_d       = pkt_cnt_q;
      aidx_d          = aidx_q;
      sidx_d          = sidx_q;
      cont_d          = cont_q;
      bus.wdata_ready = 1'b0;

      if (load) flit_d = '0;

      unique case (state_q)
         StIdle: begin
            if (bus.cmd_valid) begin
               rw_d      = bus.cmd_rw;
               hdr_d     = mam_hdr(bus.cmd_rw, burst_eff, bus.cmd_beats);
               addr_d    = bus.cmd_addr;
               rem_d     = burst_eff ? bus.cmd_beats : 14'd1;
               pkt_cnt_d = '0;
               aidx_d    = '0;
               sidx_d    = '0;
               cont_d    = 1'b0;
               state_d   = StDest;
            end
         end
         StDest: begin
            if (load) begin
               flit_d.data  = {MAM_DEST_TYPE, mam_id};
               flit_d.valid = 1'b1;
               pkt_cnt_d    = pkt_cnt_q + CntW'(1);
               state_d      = StSrc;
            end
         end
         StSrc: begin
            if (load) begin
               flit_d.data  = {MAM_SRC_TYPE, id};
               flit_d.valid = 1'b1;
               pkt_cnt_d    = pkt_cnt_q + CntW'(1);
               state_d      = cont_q ? StData : StHdr;
            end
         end
         StHdr: begin
            if (load) begin
               flit_d.data  = hdr_q;
               flit_d.valid = 1'b1;
               pkt_cnt_d    = pkt_cnt_q + CntW'(1);
               state_d      = StAddr;
            end
         end
         StAddr: begin
            if (load) begin
               flit_d.data  = addr_chunk;
               flit_d.valid = 1'b1;
               pkt_cnt_d    = pkt_cnt_q + CntW'(1);
               if (aidx_q == AidxLast) begin
                  aidx_d = '0;
                  if (rw_q) begin
                     state_d = StData;
                  end else begin
                     flit_d.last = 1'b1;
                     pkt_cnt_d   = '0;
                     state_d     = StIdle;
                  end
               end else begin
                  aidx_d = aidx_q + AidxW'(1);
               end
            end
         end
         StData: begin
            // Without write data the packet stays open and the output goes idle
            if (load && bus.wdata_valid) begin
               flit_d.data  = data_chunk;
               flit_d.valid = 1'b1;
               pkt_cnt_d    = pkt_cnt_q + CntW'(1);
               if (sidx_q == SubLast) begin
                  bus.wdata_ready = 1'b1;
                  sidx_d          = '0;
                  rem_d           = rem_q - 14'd1;
                  if (rem_q == 14'd1) begin
                     flit_d.last = 1'b1;
                     pkt_cnt_d   = '0;
                     state_d     = StIdle;
                  end else if (pkt_full) begin
                     flit_d.last = 1'b1;
                     pkt_cnt_d   = '0;
                     cont_d      = 1'b1;
                     state_d     = StDest;
                  end
               end else begin
                  sidx_d = sidx_q + SubW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         flit_q    <= '0;
         rw_q      <= 1'b0;
         hdr_q     <= '0;
         addr_q    <= '0;
         rem_q     <= '0;
         pkt_cnt_q <= '0;
         aidx_q    <= '0;
         sidx_q    <= '0;
         cont_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         flit_q    <= flit_d;
         rw_q      <= rw_d;
         hdr_q     <= hdr_d;
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         pkt_cnt_q <= pkt_cnt_d;
         aidx_q    <= aidx_d;
         sidx_q    <= sidx_d;
         cont_q    <= cont_d;
      end
   end

endmodule

// File: tb/tb_mam_host_packetizer.sv
// Self-checking bench: spec vectors from a table, reset-abort sequence, then random
// commands checked against a packet-level reference model.
module tb_mam_host_packetizer;
   import dii_package::*;

   localparam int DW   = 16;
   localparam int AW   = 32;
   localparam int MAXL = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] id;
   logic [9:0] mam_id;

   mam_host_packetizer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   mam_host_packetizer #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .MAX_PKT_LEN(MAXL)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .id    (id),
      .mam_id(mam_id),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      bit          rw;
      bit          burst;
      bit [13:0]   beats;
      bit [31:0]   addr;
      int          nwords;
      bit [15:0]   d0;
      int          rmode;
      bit [15:0]   rval;
      int          rn;
      int          wmode;
      bit [15:0]   wval;
      int          wn;
      int          gaps;
      int          nexp;
      logic [16:0] exp [13];
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Reference model: expected {last, data} flit list for one command
   function automatic void model(input bit rw, input bit burst, input bit [13:0] beats,
                                 input bit [31:0] addr, input logic [DW-1:0] words[$],
                                 output logic [16:0] q[$]);
      int af  = AW / 16;
      int fpw = DW / 16;
      int nw, cap, w, n;
      bit hb = burst && (beats != 0);
      logic [16:0] t;
      q  = {};
      nw = !rw ? 0 : (hb ? int'(beats) : 1);
      q.push_back({1'b0, 6'h00, mam_id});
      q.push_back({1'b0, 6'h10, id});
      q.push_back({1'b0, rw, hb, beats});
      for (int i = 0; i < af; i++) q.push_back({1'b0, 16'(addr >> (16 * (af - 1 - i)))});
      if (nw == 0) begin
         t = q.pop_back(); t[16] = 1'b1; q.push_back(t);
      end
      cap = (MAXL - 3 - af) / fpw;
      w   = 0;
      while (w < nw) begin
         if (w != 0) begin
            q.push_back({1'b0, 6'h00, mam_id});
            q.push_back({1'b0, 6'h10, id});
         end
         n = (nw - w < cap) ? nw - w : cap;
         for (int k = 0; k < n; k++)
            for (int s = 0; s < fpw; s++)
               q.push_back({1'b0, 16'(words[w + k] >> (16 * (fpw - 1 - s)))});
         t = q.pop_back(); t[16] = 1'b1; q.push_back(t);
         w  += n;
         cap = (MAXL - 2) / fpw;
      end
   endfunction

   // rmode/wmode: 0 none, 1 targeted stall, 2 random; exp_gaps < 0 skips the gap check
   task automatic run(input string tag, input bit rw, input bit burst, input bit [13:0] beats,
                      input bit [31:0] addr, input logic [DW-1:0] words[$],
                      input logic [16:0] exp[$], input int rmode, input bit [15:0] rval,
                      input int rn, input int wmode, input bit [15:0] wval, input int wn,
                      input int exp_gaps);
      logic [16:0] got[$];
      int      widx = 0, acc_cyc = -1, first_cyc = -1, gaps = 0, tail = 0;
      int      rstall = 0, wstall = 0, cyc;
      bit      pending = 1, rdone = 0, wdone = 0, any_wready = 0, wv;
      bit      prev_valid = 0, prev_ready = 1;
      dii_flit prev_flit = '0;
      for (cyc = 0; cyc < 2000 && tail < 4; cyc++) begin
         @(negedge clk);
         if (prev_valid && !prev_ready)
            check({tag, " hold"}, 32'(bus.debug_out), 32'(prev_flit));
         if (first_cyc < 0 && bus.debug_out.valid) first_cyc = cyc;
         if (first_cyc >= 0 && got.size() < exp.size() && !bus.debug_out.valid) gaps++;
         if (rmode == 1 && !rdone && bus.debug_out.valid && bus.debug_out.data == rval) begin
            rstall = rn; rdone = 1;
         end
         if (rmode == 2) bus.debug_out_ready = ($urandom_range(0, 3) != 0);
         else            bus.debug_out_ready = (rstall == 0);
         if (rstall > 0) rstall--;
         if (wmode == 1 && !wdone && widx < words.size() && words[widx] == wval &&
             bus.debug_out.valid && bus.debug_out.data == {6'h10, id}) begin
            wstall = wn; wdone = 1;
         end
         wv = (widx < words.size()) && (wstall == 0) && (wmode != 2 || $urandom_range(0, 3) != 0);
         if (wstall > 0) wstall--;
         bus.wdata_valid = wv;
         bus.wdata       = (widx < words.size()) ? words[widx] : '0;
         bus.cmd_valid   = pending;
         bus.cmd_rw      = rw;
         bus.cmd_burst   = burst;
         bus.cmd_beats   = beats;
         bus.cmd_addr    = addr;
         #1;
         if (bus.cmd_valid && bus.cmd_ready) begin pending = 0; acc_cyc = cyc; end
         if (bus.wdata_ready) any_wready = 1;
         if (bus.wdata_valid && bus.wdata_ready) widx++;
         if (bus.debug_out.valid && bus.debug_out_ready)
            got.push_back({bus.debug_out.last, bus.debug_out.data});
         prev_valid = bus.debug_out.valid;
         prev_ready = bus.debug_out_ready;
         prev_flit  = bus.debug_out;
         if (!pending && got.size() >= exp.size()) tail++;
      end
      bus.cmd_valid       = 1'b0;
      bus.wdata_valid     = 1'b0;
      bus.debug_out_ready = 1'b1;
      check({tag, " timeout"}, 32'(tail >= 4), 32'd1);
      check({tag, " flit count"}, got.size(), exp.size());
      for (int i = 0; i < got.size() && i < exp.size(); i++)
         check($sformatf("%s flit%0d", tag, i), 32'(got[i]), 32'(exp[i]));
      check({tag, " words consumed"}, widx, words.size());
      check({tag, " latency"}, first_cyc - acc_cyc, 2);
      if (!rw) check({tag, " wdata_ready on read"}, 32'(any_wready), 32'd0);
      if (exp_gaps >= 0) check({tag, " idle cycles"}, gaps, exp_gaps);
   endtask

   task automatic set_vec(input int i, input string name, input bit rw, input bit burst,
                          input bit [13:0] beats, input bit [31:0] addr, input int nwords,
                          input bit [15:0] d0, input int rmode, input bit [15:0] rval,
                          input int rn, input int wmode, input bit [15:0] wval, input int wn,
                          input int gaps, input int nexp);
      vecs[i].name  = name;  vecs[i].rw    = rw;    vecs[i].burst = burst;
      vecs[i].beats = beats; vecs[i].addr  = addr;  vecs[i].nwords = nwords;
      vecs[i].d0    = d0;    vecs[i].rmode = rmode; vecs[i].rval  = rval;
      vecs[i].rn    = rn;    vecs[i].wmode = wmode; vecs[i].wval  = wval;
      vecs[i].wn    = wn;    vecs[i].gaps  = gaps;  vecs[i].nexp  = nexp;
   endtask

   initial begin
      logic [DW-1:0] words[$];
      logic [16:0]   expq[$];
      bit            seen, fired, acc;
      int            nvalid;

      // Vector table: command, stalls and the literal expected flit stream
      set_vec(0, "burst6", 1, 1, 6, 32'h0, 6, 16'h1, 0, 0, 0, 0, 0, 0, 0, 13);
      vecs[0].exp = '{17'h00001, 17'h04000, 17'h0C006, 17'h00000, 17'h00000, 17'h00001,
                      17'h00002, 17'h10003, 17'h00001, 17'h04000, 17'h00004, 17'h00005,
                      17'h10006};
      set_vec(1, "single", 1, 0, 0, 32'h0, 1, 16'hF, 0, 0, 0, 0, 0, 0, 0, 6);
      vecs[1].exp = '{17'h00001, 17'h04000, 17'h08000, 17'h00000, 17'h00000, 17'h1000F,
                      17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0};
      set_vec(2, "read4", 0, 1, 4, 32'h12345678, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 5);
      vecs[2].exp = '{17'h00001, 17'h04000, 17'h04004, 17'h01234, 17'h15678,
                      17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0};
      set_vec(3, "ready_stall", 1, 1, 6, 32'h0, 6, 16'h1, 1, 16'h2, 3, 0, 0, 0, 0, 13);
      vecs[3].exp = vecs[0].exp;
      set_vec(4, "wdata_stall", 1, 1, 6, 32'h0, 6, 16'h1, 0, 0, 0, 1, 16'h4, 2, 2, 13);
      vecs[4].exp = vecs[0].exp;

      rst                 = 1'b1;
      id                  = 10'd0;
      mam_id              = 10'd1;
      bus.cmd_valid       = 1'b0;
      bus.cmd_rw          = 1'b0;
      bus.cmd_addr        = '0;
      bus.cmd_burst       = 1'b0;
      bus.cmd_beats       = '0;
      bus.wdata_valid     = 1'b0;
      bus.wdata           = '0;
      bus.debug_out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset valid", 32'(bus.debug_out.valid), 32'd0);
      check("reset last", 32'(bus.debug_out.last), 32'd0);
      check("reset data", 32'(bus.debug_out.data), 32'd0);
      check("reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("reset wdata_ready", 32'(bus.wdata_ready), 32'd0);

      foreach (vecs[v]) begin
         words = {};
         expq  = {};
         for (int i = 0; i < vecs[v].nwords; i++) words.push_back(vecs[v].d0 + DW'(i));
         for (int i = 0; i < vecs[v].nexp; i++) expq.push_back(vecs[v].exp[i]);
         run(vecs[v].name, vecs[v].rw, vecs[v].burst, vecs[v].beats, vecs[v].addr, words,
             expq, vecs[v].rmode, vecs[v].rval, vecs[v].rn, vecs[v].wmode, vecs[v].wval,
             vecs[v].wn, vecs[v].gaps);
      end

      // Reset while the HDR flit of a single write is on the output
      seen = 0; fired = 0; acc = 0;
      bus.wdata           = 16'h000F;
      bus.wdata_valid     = 1'b1;
      bus.cmd_rw          = 1'b1;
      bus.cmd_burst       = 1'b0;
      bus.cmd_beats       = '0;
      bus.cmd_addr        = '0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         bus.cmd_valid = !acc;
         if (bus.debug_out.valid && bus.debug_out.data == 16'h8000) begin
            seen = 1;
            rst  = 1'b1;
         end
         #1;
         if (bus.cmd_valid && bus.cmd_ready) acc = 1;
      end
      check("reset abort: HDR reached", 32'(seen), 32'd1);
      @(negedge clk);
      rst             = 1'b0;
      bus.cmd_valid   = 1'b0;
      check("reset abort valid", 32'(bus.debug_out.valid), 32'd0);
      check("reset abort cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("reset abort wdata_ready", 32'(bus.wdata_ready), 32'd0);
      bus.wdata_valid = 1'b0;
      nvalid = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.debug_out.valid) nvalid++;
      end
      check("reset abort no further flits", nvalid, 0);
      words = {16'h000F};
      expq  = {};
      for (int i = 0; i < vecs[1].nexp; i++) expq.push_back(vecs[1].exp[i]);
      run("after_reset", 1, 0, 0, 32'h0, words, expq, 0, 0, 0, 0, 0, 0, 0);

      // Random commands against the reference model
      for (int t = 0; t < 30; t++) begin
         bit        rw, burst;
         bit [13:0] beats;
         bit [31:0] addr;
         int        nw;
         rw     = 1'($urandom_range(0, 1));
         burst  = 1'($urandom_range(0, 1));
         beats  = 14'($urandom_range(0, 14));
         addr   = $urandom;
         id     = 10'($urandom_range(0, 1023));
         mam_id = 10'($urandom_range(0, 1023));
         nw     = !rw ? 0 : ((burst && beats != 0) ? int'(beats) : 1);
         words  = {};
         for (int i = 0; i < nw; i++) words.push_back(DW'($urandom));
         model(rw, burst, beats, addr, words, expq);
         run($sformatf("rand%0d", t), rw, burst, beats, addr, words, expq,
             2 * $urandom_range(0, 1), 0, 0, 2 * $urandom_range(0, 1), 0, 0, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
